blob_frame_feeder: RTL and testbench
====================================

# blob_frame_feeder

Captures one thresholded camera frame into an on-chip 1-bit frame store and replays it as a gap-free binary pixel stream for the blob-counting stage. The camera delivers pixels sporadically, with blanking gaps. The blob stage needs exactly one pixel per clock once its valid rises, and it must see valid held until it reports a result. This block sits between the camera RGB path and the blob counter, and it owns that rate conversion and handshake.

## Interface
Parameters:
- IMG_COL, 640, pixels per row
- IMG_ROW, 480, rows per frame
- INVERT, 0, 1 = foreground is luma below threshold

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to capture and process the next frame
- i_frame_start  in  1  one-cycle pulse marking start of a camera frame; may coincide with i_pix_valid for pixel 0
- i_pix_valid  in  1  qualifies i_red/i_green/i_blue
- i_red, i_green, i_blue  in  12 each  camera pixel
- i_thresh  in  12  luma threshold, sampled when ARM is entered
- i_blob_done  in  1  result-valid from blob stage
- o_valid  out  1  frame-valid to blob stage
- o_seq  out  1  binary pixel to blob stage
- o_busy  out  1  high in every state except IDLE
- o_short  out  1  sticky: a capture was restarted because of an early frame start; cleared on i_start

## Operation
- Reset (asynchronous): state IDLE; o_valid=0, o_seq=0, o_busy=0, o_short=0; all counters 0. The frame store is not cleared.
- Luma: sum = R + 2·G + B (14 bits, no overflow); luma = sum[13:2].
- Binarisation: bit = (luma >= thresh_r) XOR INVERT.
- Frame store: IMG_COL·IMG_ROW × 1 bit, single write port and single read port, 1-cycle read latency. Address is 19 bits, row-major.

State machine:
- IDLE: on i_start, latch i_thresh into thresh_r, clear o_short, and go to ARM.
- ARM: wait for i_frame_start. Then go to CAPTURE with wr_addr=0. If i_pix_valid is high in the same cycle, that pixel is written at address 0 and wr_addr becomes 1.
- CAPTURE: each i_pix_valid writes the bit at wr_addr and increments wr_addr.
  - After the write to address N-1 (N = IMG_COL·IMG_ROW), go to STREAM.
  - If i_frame_start arrives with wr_addr < N, set o_short, restart at wr_addr=0, and apply the same same-cycle rule as ARM.
- STREAM:
  - Cycle s0 (first STREAM cycle): o_valid rises and rd_addr=0 is issued.
  - rd_addr increments every cycle up to N-1, with no stalls.
  - o_seq carries pixel k in cycle s0+1+k.
  - After pixel N-1 has been driven, o_seq=0 and the state goes to WAIT_DONE.
- WAIT_DONE: hold o_valid=1 and o_seq=0. When i_blob_done is sampled high, drop o_valid in the next cycle and go to IDLE.

Ignored inputs:
- i_start is ignored in every state except IDLE.
- Camera inputs are ignored outside ARM and CAPTURE.
- i_frame_start in STREAM or WAIT_DONE is ignored.
- i_blob_done outside WAIT_DONE is ignored.

## Timing
- o_valid, o_seq, o_busy and o_short are registered outputs.
- Capture throughput: one pixel per cycle with arbitrary gaps.
- Stream: exactly N consecutive o_seq cycles, s0+1 … s0+N, with o_valid high continuously from s0 until the cycle after i_blob_done is sampled.
- o_valid is never low for a single cycle inside a frame.
- Latency from the last captured pixel write to o_valid rising: 1 cycle.
- o_valid rising to first pixel on o_seq: 1 cycle.
- Minimum gap between consecutive o_valid frames: 1 low cycle, plus ARM and CAPTURE time.
- Reset asserted mid-STREAM drops o_valid immediately (asynchronously); the blob stage then sees valid low and returns to idle.

## Test plan
- Uniform frame: thresh=0x800, all pixels R=G=B=0xFFF with random valid gaps → o_valid high; o_seq=1 for exactly 307200 consecutive cycles starting at s0+1; o_seq=0 afterwards.
- Pattern check: pixel k has bit = k[0] (luma 0xFFF vs 0x000), thresh=0x800, INVERT=0 → o_seq at s0+1+k equals k[0] for all k; pixel 0 is supplied together with i_frame_start.
- Handshake: i_blob_done pulsed 50 cycles after the stream ends → o_valid stays high for those cycles and is low in the cycle after the pulse; state is IDLE and o_busy=0.
- Short frame: i_frame_start at wr_addr=1000, then a full frame → o_short=1, and the streamed data equals the second frame only; the next i_start clears o_short.
- Threshold boundary: luma exactly equal to thresh (R=G=B=0x400, thresh=0x400) → bit 1; with INVERT=1 → bit 0. i_start during STREAM has no effect.
- Reset at STREAM pixel 1000 → o_valid=0 and o_busy=0 immediately; after reset, a new i_start and frame replay correctly.

Source files
------------

// File: rtl/blob_frame_feeder_if.sv
// Camera-side capture inputs and blob-stage handshake for blob_frame_feeder.
// The slave modport is the feeder's view; the master modport is the driver's view.
interface blob_frame_feeder_if #(
  parameter int DATA_W = 12
);
  logic              i_start;
  logic              i_frame_start;
  logic              i_pix_valid;
  logic [DATA_W-1:0] i_red;
  logic [DATA_W-1:0] i_green;
  logic [DATA_W-1:0] i_blue;
  logic [DATA_W-1:0] i_thresh;
  logic              i_blob_done;
  logic              o_valid;
  logic              o_seq;
  logic              o_busy;
  logic              o_short;

  modport slave (
    input  i_start, i_frame_start, i_pix_valid, i_red, i_green, i_blue,
           i_thresh, i_blob_done,
    output o_valid, o_seq, o_busy, o_short
  );

  modport master (
    output i_start, i_frame_start, i_pix_valid, i_red, i_green, i_blue,
           i_thresh, i_blob_done,
    input  o_valid, o_seq, o_busy, o_short
  );
endinterface

// File: rtl/blob_frame_feeder.sv
// Captures one thresholded frame into a 1-bit store, then replays it as a
// gap-free pixel stream with a valid held until the blob stage reports done.
module blob_frame_feeder #(
  parameter int DATA_W  = 12,
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter bit INVERT  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  blob_frame_feeder_if.slave   bus
);
  localparam int N      = IMG_COL * IMG_ROW;
  localparam int ADDR_W = 19;
  localparam int MEM_AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_STREAM,
    S_WAIT_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] thresh_r;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_sel;
  logic              wr_en;
  logic              restart;
  logic              short_set;
  logic              pix_bit;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              vld_p0;
  logic              seq_p1;
  logic              valid_q;
  logic              busy_q;
  logic              short_q;

  logic mem [0:N-1];

  function automatic logic [DATA_W-1:0] luma_f(
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] g,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[DATA_W+1:2];
  endfunction

  function automatic logic binarise_f(
    input logic [DATA_W-1:0] luma,
    input logic [DATA_W-1:0] thresh
  );
    return (luma >= thresh) ^ INVERT;
  endfunction

  assign pix_bit = binarise_f(luma_f(bus.i_red, bus.i_green, bus.i_blue), thresh_r);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // A frame start in ARM or CAPTURE rewinds the write pointer to 0, and a
  // pixel arriving in the same cycle lands at address 0.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_sel     = wr_addr;
    restart    = 1'b0;
    short_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_start) state_next = S_ARM;
      end
      S_ARM: begin
        if (bus.i_frame_start) begin
          state_next = S_CAPTURE;
          restart    = 1'b1;
          wr_sel     = '0;
          wr_en      = bus.i_pix_valid;
          if (wr_en && (wr_sel == LAST)) state_next = S_STREAM;
        end
      end
      S_CAPTURE: begin
        if (bus.i_frame_start) begin
          restart   = 1'b1;
          short_set = 1'b1;
          wr_sel    = '0;
        end
        wr_en = bus.i_pix_valid;
        if (wr_en && (wr_sel == LAST)) state_next = S_STREAM;
      end
      S_STREAM: begin
        if (rd_addr_p0 == LAST) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.i_blob_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if ((state == S_IDLE) && bus.i_start) thresh_r <= bus.i_thresh;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= (wr_sel == LAST) ? '0 : wr_sel + ADDR_W'(1);
    end else if (restart) begin
      wr_addr <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_sel[MEM_AW-1:0]] <= pix_bit;
  end

  // ---- p0: read address issued, one per STREAM cycle ----
  assign vld_p0 = (state == S_STREAM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_addr_p0 <= '0;
    else          rd_addr_p0 <= vld_p0 ? rd_addr_p0 + ADDR_W'(1) : '0;
  end

  // ---- p1: read data registered straight onto o_seq, zero outside the stream ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) seq_p1 <= 1'b0;
    else          seq_p1 <= vld_p0 ? mem[rd_addr_p0[MEM_AW-1:0]] : 1'b0;
  end

  // Status flags follow the next state so o_valid rises in the first STREAM cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      valid_q <= (state_next == S_STREAM) || (state_next == S_WAIT_DONE);
      busy_q  <= (state_next != S_IDLE);
      if ((state == S_IDLE) && bus.i_start) short_q <= 1'b0;
      else if (short_set)                   short_q <= 1'b1;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_seq   = seq_p1;
  assign bus.o_busy  = busy_q;
  assign bus.o_short = short_q;
endmodule

// File: tb/tb_blob_frame_feeder.sv
// Bench for blob_frame_feeder on a 16x8 frame, two instances (INVERT=0/1)
// sharing one stimulus; expected stream bits are queued at capture time.
module tb_blob_frame_feeder;
  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int N    = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  blob_frame_feeder_if ifc0 ();
  blob_frame_feeder_if ifc1 ();

  assign ifc1.i_start       = ifc0.i_start;
  assign ifc1.i_frame_start = ifc0.i_frame_start;
  assign ifc1.i_pix_valid   = ifc0.i_pix_valid;
  assign ifc1.i_red         = ifc0.i_red;
  assign ifc1.i_green       = ifc0.i_green;
  assign ifc1.i_blue        = ifc0.i_blue;
  assign ifc1.i_thresh      = ifc0.i_thresh;
  assign ifc1.i_blob_done   = ifc0.i_blob_done;

  blob_frame_feeder #(.IMG_COL(COLS), .IMG_ROW(ROWS), .INVERT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc0));
  blob_frame_feeder #(.IMG_COL(COLS), .IMG_ROW(ROWS), .INVERT(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc1));

  typedef struct {
    logic [11:0] r, g, b, th;
    logic        e0, e1;
  } vec_t;

  vec_t       tbl[8];
  logic [1:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [11:0] th);
    ifc0.i_start  = 1'b1;
    ifc0.i_thresh = th;
    step();
    ifc0.i_start  = 1'b0;
    ifc0.i_thresh = $urandom_range(0, 4095);
    chk("busy_after_start", ifc0.o_busy, 1);
    chk("short_cleared", ifc0.o_short, 0);
  endtask

  // Drives frame_start plus npix pixels with random gaps; leaves time in the
  // cycle after the last pixel (s0 when npix == N).
  task automatic capture(input int npix, input bit pattern,
                         input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                         input logic e0, input logic e1, input bit fs_with_pix);
    int gaps;
    sb.delete();
    if (!fs_with_pix) begin
      ifc0.i_frame_start = 1'b1;
      step();
      ifc0.i_frame_start = 1'b0;
    end
    for (int k = 0; k < npix; k++) begin
      gaps = (k == 0) ? 0 : $urandom_range(0, 2);
      for (int gi = 0; gi < gaps; gi++) begin
        ifc0.i_pix_valid = 1'b0;
        ifc0.i_red   = $urandom_range(0, 4095);
        ifc0.i_green = $urandom_range(0, 4095);
        ifc0.i_blue  = $urandom_range(0, 4095);
        step();
      end
      ifc0.i_pix_valid = 1'b1;
      if (pattern) begin
        ifc0.i_red   = k[0] ? 12'hFFF : 12'h000;
        ifc0.i_green = k[0] ? 12'hFFF : 12'h000;
        ifc0.i_blue  = k[0] ? 12'hFFF : 12'h000;
        sb.push_back({~k[0], k[0]});
      end else begin
        ifc0.i_red   = r;
        ifc0.i_green = g;
        ifc0.i_blue  = b;
        sb.push_back({e1, e0});
      end
      if ((k == 0) && fs_with_pix) ifc0.i_frame_start = 1'b1;
      step();
      ifc0.i_frame_start = 1'b0;
      ifc0.i_pix_valid   = 1'b0;
    end
  endtask

  // Called in s0; start_at >= 0 pulses i_start and i_blob_done mid-stream.
  task automatic check_stream(input int start_at);
    logic [1:0] e;
    chk("valid_at_s0", ifc0.o_valid, 1);
    chk("seq_at_s0", ifc0.o_seq, 0);
    for (int k = 0; k < N; k++) begin
      ifc0.i_start     = (k == start_at);
      ifc0.i_blob_done = (k == start_at);
      ifc0.i_thresh    = 12'h000;
      step();
      ifc0.i_start     = 1'b0;
      ifc0.i_blob_done = 1'b0;
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
        e = 2'b00;
      end else begin
        e = sb.pop_front();
      end
      chk($sformatf("seq0_pix%0d", k), ifc0.o_seq, e[0]);
      chk($sformatf("seq1_pix%0d", k), ifc1.o_seq, e[1]);
      chk("valid_in_stream", ifc0.o_valid, 1);
    end
    step();
    chk("seq_after_stream", ifc0.o_seq, 0);
    chk("seq1_after_stream", ifc1.o_seq, 0);
    chk("valid_after_stream", ifc0.o_valid, 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  task automatic handshake(input int gap);
    for (int i = 0; i < gap; i++) begin
      step();
      chk("valid_wait_done", ifc0.o_valid, 1);
      chk("seq_wait_done", ifc0.o_seq, 0);
    end
    ifc0.i_blob_done = 1'b1;
    step();
    ifc0.i_blob_done = 1'b0;
    chk("valid_after_done", ifc0.o_valid, 0);
    chk("busy_after_done", ifc0.o_busy, 0);
    chk("valid1_after_done", ifc1.o_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h800, 1'b1, 1'b0};
    tbl[1] = '{12'h000, 12'h000, 12'h000, 12'h800, 1'b0, 1'b1};
    tbl[2] = '{12'h400, 12'h400, 12'h400, 12'h400, 1'b1, 1'b0};
    tbl[3] = '{12'h3FF, 12'h3FF, 12'h3FF, 12'h400, 1'b0, 1'b1};
    tbl[4] = '{12'hFFF, 12'h000, 12'h000, 12'h3FF, 1'b1, 1'b0};
    tbl[5] = '{12'h000, 12'hFFF, 12'h000, 12'h800, 1'b0, 1'b1};
    tbl[6] = '{12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0};
    tbl[7] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0};

    ifc0.i_start = 1'b0; ifc0.i_frame_start = 1'b0; ifc0.i_pix_valid = 1'b0;
    ifc0.i_red = '0; ifc0.i_green = '0; ifc0.i_blue = '0;
    ifc0.i_thresh = '0; ifc0.i_blob_done = 1'b0;

    repeat (3) step();
    chk("rst_valid", ifc0.o_valid, 0);
    chk("rst_seq", ifc0.o_seq, 0);
    chk("rst_busy", ifc0.o_busy, 0);
    chk("rst_short", ifc0.o_short, 0);
    chk("rst_valid1", ifc1.o_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("idle_busy", ifc0.o_busy, 0);

    for (int i = 0; i < 8; i++) begin
      do_start(tbl[i].th);
      capture(N, 1'b0, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].e0, tbl[i].e1, i[0]);
      check_stream(-1);
      handshake(3);
    end

    // Alternating pattern, pixel 0 with frame start, done 50 cycles late.
    do_start(12'h800);
    capture(N, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_stream(-1);
    handshake(50);

    // Early frame start after 50 pixels: only the second frame streams.
    do_start(12'h800);
    capture(50, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b1);
    chk("short_before_restart", ifc0.o_short, 0);
    capture(N, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("short_set", ifc0.o_short, 1);
    check_stream(-1);
    handshake(2);
    chk("short_sticky", ifc0.o_short, 1);

    // i_start and i_blob_done pulsed mid-stream are ignored.
    do_start(12'h800);
    capture(N, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_stream(5);
    handshake(1);

    // Asynchronous reset in the middle of the stream.
    do_start(12'h800);
    capture(N, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("valid_s0_pre_reset", ifc0.o_valid, 1);
    repeat (101) step();
    chk("valid_before_reset", ifc0.o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", ifc0.o_valid, 0);
    chk("midrst_busy", ifc0.o_busy, 0);
    chk("midrst_seq", ifc0.o_seq, 0);
    chk("midrst_valid1", ifc1.o_valid, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", ifc0.o_busy, 0);
    do_start(12'h400);
    capture(N, 1'b0, 12'h400, 12'h400, 12'h400, 1'b1, 1'b0, 1'b0);
    check_stream(-1);
    handshake(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
